// File: rtl/midi_square_voice.sv
// rtl/midi_square_voice.sv - single-voice square-wave tone generator with linear attack/release envelope
module midi_square_voice #(
  parameter int CLOCK_FREQ   = 100000000,
  parameter int SAMPLE_RATE  = 48000,
  parameter int ATTACK_STEP  = 4,
  parameter int RELEASE_STEP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       note_on,
  input  logic [9:0] delay,
  input  logic [7:0] velocity,
  output logic [7:0] sample_out,
  output logic       sample_valid,
  output logic       busy
);

  localparam int TICK_DIV = CLOCK_FREQ / SAMPLE_RATE;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [6:0] ATK = 7'(ATTACK_STEP);
  localparam logic [6:0] REL = 7'(RELEASE_STEP);

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

  state_t        state, state_nx;
  logic [6:0]    amp, amp_nx;
  logic [6:0]    target, target_nx;
  logic [9:0]    period, period_nx;
  logic [9:0]    phase_cnt, phase_nx;
  logic          polarity, polarity_nx;
  logic [CW-1:0] presc;
  logic          tick;
  logic          tick_d;
  logic          note_start;
  logic          note_stop;
  logic [6:0]    attack_amp;
  logic          unused_vel_msb;

  // Only the 7-bit MIDI velocity range is meaningful.
  assign unused_vel_msb = velocity[7];

  assign tick       = (presc == TICK_LAST);
  assign note_start = start && note_on && (delay != 10'd0);
  assign note_stop  = start && !note_start;
  assign busy       = (state != IDLE);

  // Free-running sample-rate prescaler, independent of voice state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Attack moves amp toward target in either direction, clamping at target.
  always_comb begin
    attack_amp = target;
    if (amp < target) begin
      if ((target - amp) > ATK) attack_amp = amp + ATK;
    end else if (amp > target) begin
      if ((amp - target) > ATK) attack_amp = amp - ATK;
    end
  end

  // Next-state: note events win over the tick; otherwise step phase and envelope on tick.
  always_comb begin
    state_nx    = state;
    amp_nx      = amp;
    target_nx   = target;
    period_nx   = period;
    phase_nx    = phase_cnt;
    polarity_nx = polarity;
    if (note_start) begin
      period_nx   = delay;
      target_nx   = velocity[6:0];
      phase_nx    = 10'd0;
      polarity_nx = 1'b1;
      state_nx    = ATTACK;
    end else if (note_stop) begin
      if (state == ATTACK || state == SUSTAIN) state_nx = RELEASE;
    end else if (tick && state != IDLE) begin
      if (phase_cnt == period - 10'd1) begin
        phase_nx    = 10'd0;
        polarity_nx = !polarity;
      end else begin
        phase_nx = phase_cnt + 10'd1;
      end
      case (state)
        ATTACK: begin
          amp_nx = attack_amp;
          if (attack_amp == target) state_nx = SUSTAIN;
        end
        RELEASE: begin
          if (amp > REL) begin
            amp_nx = amp - REL;
          end else begin
            amp_nx   = 7'd0;
            state_nx = IDLE;
          end
        end
        default: begin
          amp_nx = amp;
        end
      endcase
    end
  end

  // Voice state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      amp       <= 7'd0;
      target    <= 7'd0;
      period    <= 10'd0;
      phase_cnt <= 10'd0;
      polarity  <= 1'b0;
    end else begin
      state     <= state_nx;
      amp       <= amp_nx;
      target    <= target_nx;
      period    <= period_nx;
      phase_cnt <= phase_nx;
      polarity  <= polarity_nx;
    end
  end

  // Sample output one cycle after the tick update, from the updated registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_d       <= 1'b0;
      sample_valid <= 1'b0;
      sample_out   <= 8'd128;
    end else begin
      tick_d       <= tick;
      sample_valid <= tick_d;
      if (tick_d) begin
        if (state == IDLE) begin
          sample_out <= 8'd128;
        end else if (polarity) begin
          sample_out <= 8'd128 + {1'b0, amp};
        end else begin
          sample_out <= 8'd128 - {1'b0, amp};
        end
      end
    end
  end

endmodule

// File: doc/midi_square_voice.md
# midi_square_voice

Single-voice square-wave tone generator with a linear attack/release envelope. It sits directly downstream of the MIDI decode control/datapath pair and consumes each decoded note event, which arrives as a start strobe, a note-on/off flag, a half-period and a velocity. It emits unsigned 8-bit audio samples at a fixed sample rate with a one-cycle valid strobe, ready for a DAC/PWM output stage.

## Interface
- ClockFreq, 100000000, system clock frequency in Hz
- SampleRate, 48000, output sample rate in Hz; TickDiv = ClockFreq/SampleRate (integer division, must be ≥2)
- AttackStep, 4, amplitude increment per sample during attack (1..127)
- ReleaseStep, 2, amplitude decrement per sample during release (1..127)
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle event strobe from MIDI decode
- NoteOn  in  1  1 = note-on, 0 = note-off; sampled only when Start=1
- Delay  in  10  half-period of the tone in samples; sampled only when Start=1
- Velocity  in  8  note velocity; only bits [6:0] used; sampled only when Start=1
- SampleOut  out  8  offset-binary sample, midscale 128
- SampleValid  out  1  one-cycle strobe, one per sample period
- Busy  out  1  high whenever the state is not IDLE

## Operation
- Prescaler: free-running counter 0..TickDiv-1. Tick = (count == TickDiv-1), after which the counter wraps to 0. It runs regardless of voice state.
- Registers: State {IDLE, ATTACK, SUSTAIN, RELEASE}, Amp[6:0], Target[6:0], Period[9:0], PhaseCnt[9:0], Polarity.
- Start with NoteOn=1 and Delay≠0, in any state:
  - Period←Delay, Target←Velocity[6:0], PhaseCnt←0, Polarity←1, State←ATTACK.
  - Amp is retained. Retrigger does not reset amplitude.
- Start with NoteOn=1 and Delay=0 is treated as note-off.
- Start with note-off:
  - ATTACK or SUSTAIN → RELEASE.
  - IDLE and RELEASE are unchanged.
- On Tick, when Start=0 and State≠IDLE:
  - Phase: if PhaseCnt == Period-1, then PhaseCnt←0 and Polarity toggles; otherwise PhaseCnt+1.
  - ATTACK: move Amp toward Target by AttackStep, clamped at Target. Amp may also decrease toward a lower Target. When the resulting Amp equals Target, State←SUSTAIN in the same update.
  - SUSTAIN: Amp is held.
  - RELEASE: Amp←max(Amp-ReleaseStep, 0). When the result is 0, State←IDLE.
- Start and Tick in the same cycle: Start has priority. The phase and envelope step is skipped for that tick, but the sample is still emitted.
- Target = 0 on note-on: ATTACK→SUSTAIN at the first tick, with silent output until note-off.
- Sample value, computed from the registers after the tick update:
  - IDLE: 128.
  - Otherwise: Polarity ? 128+Amp : 128-Amp. Range 1..255, no overflow is possible.

## Timing
- Reset asserted: all registers clear immediately, without waiting for a clock edge.
  - SampleOut=128, SampleValid=0, Busy=0, State=IDLE, Amp=0, prescaler=0.
- First SampleValid: TickDiv+1 rising edges after Reset deasserts.
- Latency from tick to output: the tick is the cycle in which the prescaler equals TickDiv-1. Registers update at that edge. SampleOut and SampleValid are registered and update at the next edge.
  - Result: SampleValid is high for exactly 1 cycle every TickDiv cycles.
  - SampleOut is stable between strobes.
- Start → Busy high: Busy rises on the edge that samples Start (Busy is registered from State).
- Busy falls on the edge where RELEASE reaches Amp=0. The sample emitted for that tick is 128.
- Reset deasserted mid-note: the voice restarts from IDLE. No event is remembered.

## Test plan
Unless stated otherwise: ClockFreq=1000, SampleRate=100 (TickDiv=10), AttackStep=4, ReleaseStep=2.

1. Reset low then high, no events → SampleValid every 10 cycles, first after 11 edges, SampleOut=128, Busy=0.
2. Note-on, Delay=3, Velocity=20 → samples 132, 136, 116, 112, 108, 148, 148, 148, 108… and Busy=1. SUSTAIN is reached on the 5th sample.
3. Note-off after the samples in scenario 2 → Amp 18, 16, …, 0 over 10 samples. Busy falls with the 10th. All following samples are 128.
4. Note-on with Velocity=10 issued during release at Amp=14 → next sample has Amp=10 and SUSTAIN. Phase restarts with Polarity=1 (sample 138).
5. Boundary events:
   - Start with Delay=0 while IDLE → no change, Busy stays 0.
   - Start coincident with a Tick → that sample shows the unchanged Amp, and the step is applied from the next tick onward.
   - Velocity=200 → Target=72.
6. Reset pulled low mid-SUSTAIN, off-edge → SampleOut=128, Busy=0, SampleValid=0 immediately. Prescaler cadence restarts after release.
